button_debouncer: RTL and testbench

//  Synchronises a raw asynchronous input (push-button/switch) into clk and filters contact bounce.

---
 rtl/button_debouncer_pkg.sv | 21 ++
 rtl/button_debouncer_if.sv | 19 +
 rtl/button_debouncer_synchronizer.sv | 24 ++
 rtl/button_debouncer.sv | 128 ++++++++++++
 tb/tb_button_debouncer.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/button_debouncer_pkg.sv
// Shared types and helpers for the button debouncer FSM.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW   = 2'd0,
    PENDING_HIGH = 2'd1,
    STABLE_HIGH  = 2'd2,
    PENDING_LOW  = 2'd3
  } debounce_state_t;

  localparam int GLITCH_CNT_W = 8;

  function automatic logic state_level(input debounce_state_t s);
    return (s == STABLE_HIGH) || (s == PENDING_LOW);
  endfunction

  function automatic logic state_pending(input debounce_state_t s);
    return (s == PENDING_HIGH) || (s == PENDING_LOW);
  endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Signal bundle between the debouncer and its raw input / downstream consumer.
// glitch_count exists only when BUTTON_DEBOUNCER_GLITCH_COUNT_EN is defined.
interface button_debouncer_if;
  import debounce_pkg::*;

  logic in;
  logic debounced;
  logic busy;
`ifdef BUTTON_DEBOUNCER_GLITCH_COUNT_EN
  logic [GLITCH_CNT_W-1:0] glitch_count;

  modport master (output in, input debounced, input busy, input glitch_count);
  modport slave  (input in, output debounced, output busy, output glitch_count);
`else
  modport master (output in, input debounced, input busy);
  modport slave  (input in, output debounced, output busy);
`endif

endinterface

// File: rtl/button_debouncer_synchronizer.sv
// Generic multi-flop synchroniser with asynchronous active-low reset to RESET_VAL.
module synchronizer #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_chain <= {STAGES{RESET_VAL}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Synchronises and debounces a raw button input; outputs are registered Moore levels.
// Optional rejected-change counter enabled by BUTTON_DEBOUNCER_GLITCH_COUNT_EN.
//
// state        | meaning
// STABLE_LOW   | debounced=0, synchronised input agrees
// PENDING_HIGH | debounced=0, timing a candidate rise
// STABLE_HIGH  | debounced=1, synchronised input agrees
// PENDING_LOW  | debounced=1, timing a candidate fall
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int   SYNC_STAGES  = 2,
  parameter int   BOUNCE_TICKS = 16,
  parameter logic RESET_LEVEL  = 1'b0
) (
  input logic             clk,
  input logic             rst,
  button_debouncer_if.slave bus
);

  localparam int CNT_W = $clog2(BOUNCE_TICKS);
  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(BOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam debounce_state_t RESET_STATE = RESET_LEVEL ? STABLE_HIGH : STABLE_LOW;

  logic            w_s;
  debounce_state_t r_state;
  debounce_state_t w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic            w_abort;
  logic            r_debounced;
  logic            r_busy;

  synchronizer #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (RESET_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.in),
    .q   (w_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= RESET_STATE;
      r_cnt       <= '0;
      r_debounced <= RESET_LEVEL;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_debounced <= state_level(w_state_nxt);
      r_busy      <= state_pending(w_state_nxt);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_abort     = 1'b0;
    case (r_state)
      STABLE_LOW: begin
        if (w_s) begin
          w_state_nxt = PENDING_HIGH;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        if (!w_s) begin
          w_state_nxt = PENDING_LOW;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      PENDING_HIGH: begin
        if (!w_s) begin
          w_state_nxt = STABLE_LOW;
          w_cnt_nxt   = '0;
          w_abort     = 1'b1;
        end else if (r_cnt == CNT_TC) begin
          w_state_nxt = STABLE_HIGH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      PENDING_LOW: begin
        if (w_s) begin
          w_state_nxt = STABLE_HIGH;
          w_cnt_nxt   = '0;
          w_abort     = 1'b1;
        end else if (r_cnt == CNT_TC) begin
          w_state_nxt = STABLE_LOW;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = RESET_STATE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.debounced = r_debounced;
  assign bus.busy      = r_busy;

`ifdef BUTTON_DEBOUNCER_GLITCH_COUNT_EN
  logic [GLITCH_CNT_W-1:0] r_glitch_cnt;

  // Saturates so a chattering contact cannot wrap the count back to a small value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_glitch_cnt <= '0;
    end else if (w_abort && (r_glitch_cnt != '1)) begin
      r_glitch_cnt <= r_glitch_cnt + GLITCH_CNT_W'(1);
    end
  end

  assign bus.glitch_count = r_glitch_cnt;
`else
  logic w_abort_unused;
  assign w_abort_unused = w_abort;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench: stimulus queues expected output-change events, a negedge monitor pops and checks them.
module tb_button_debouncer;

  typedef struct {
    int         cyc;
    logic [1:0] val;
  } exp_evt_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;
  exp_evt_t   exp_q[$];
  logic [1:0] mon_prev;

  button_debouncer_if bus_if ();

  button_debouncer #(
    .SYNC_STAGES  (2),
    .BOUNCE_TICKS (4),
    .RESET_LEVEL  (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial mon_prev = 2'b00;

  always @(negedge clk) begin
    logic [1:0] cur;
    exp_evt_t   e;
    cur = {bus_if.debounced, bus_if.busy};
    if (cur !== mon_prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_change cyc=%0d actual={deb,busy}=%b required=no change", cyc, cur);
      end else begin
        e = exp_q.pop_front();
        if ((e.cyc != cyc) || (e.val !== cur)) begin
          failures++;
          $display("FAIL output_event actual cyc=%0d {deb,busy}=%b required cyc=%0d {deb,busy}=%b",
                   cyc, cur, e.cyc, e.val);
        end
      end
      mon_prev = cur;
    end
  end

  task automatic push_evt(input int c, input logic [1:0] v);
    exp_evt_t e;
    e.cyc = c;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_glitch(input string name, input int req);
`ifdef BUTTON_DEBOUNCER_GLITCH_COUNT_EN
    chk(name, int'(bus_if.glitch_count), req);
`else
    if (req < 0) $display("glitch counter not built: %s", name);
`endif
  endtask

  initial begin
    int c;
    checks   = 0;
    failures = 0;
    rst       = 1'b1;
    bus_if.in = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("reset_debounced", int'(bus_if.debounced), 0);
    chk("reset_busy", int'(bus_if.busy), 0);
    chk_glitch("reset_glitch", 0);
    repeat (3) tick();
    rst = 1'b1;

    // idle after release: input low, outputs must stay quiet
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("idle_debounced", int'(bus_if.debounced), 0);
      chk("idle_busy", int'(bus_if.busy), 0);
    end
    chk_glitch("idle_glitch", 0);

    // clean rise
    c = cyc;
    push_evt(c + 3, 2'b01);
    push_evt(c + 6, 2'b10);
    bus_if.in = 1'b1;
    repeat (10) tick();
    chk("rise_debounced", int'(bus_if.debounced), 1);

    // clean fall
    c = cyc;
    push_evt(c + 3, 2'b11);
    push_evt(c + 6, 2'b00);
    bus_if.in = 1'b0;
    repeat (10) tick();
    chk("fall_debounced", int'(bus_if.debounced), 0);

    // single-cycle glitch
    c = cyc;
    push_evt(c + 3, 2'b01);
    push_evt(c + 4, 2'b00);
    bus_if.in = 1'b1;
    tick();
    bus_if.in = 1'b0;
    repeat (8) tick();
    chk("glitch1_debounced", int'(bus_if.debounced), 0);
    chk_glitch("glitch1_count", 1);

    // bounce 1,0,1,0 then settle high
    c = cyc;
    push_evt(c + 3, 2'b01);
    push_evt(c + 4, 2'b00);
    push_evt(c + 5, 2'b01);
    push_evt(c + 6, 2'b00);
    push_evt(c + 7, 2'b01);
    push_evt(c + 10, 2'b10);
    bus_if.in = 1'b1; tick();
    bus_if.in = 1'b0; tick();
    bus_if.in = 1'b1; tick();
    bus_if.in = 1'b0; tick();
    bus_if.in = 1'b1;
    repeat (10) tick();
    chk("bounce_debounced", int'(bus_if.debounced), 1);
    chk_glitch("bounce_glitch", 3);

    // reset mid-pending-fall
    c = cyc;
    push_evt(c + 3, 2'b11);
    push_evt(c + 4, 2'b00);
    bus_if.in = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    chk("abort_rst_debounced", int'(bus_if.debounced), 0);
    chk("abort_rst_busy", int'(bus_if.busy), 0);
    chk_glitch("abort_rst_glitch", 0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (6) tick();
    chk("post_rst_debounced", int'(bus_if.debounced), 0);
    chk_glitch("post_rst_glitch", 0);

    // glitch counter saturation
    for (int i = 0; i < 300; i++) begin
      c = cyc;
      push_evt(c + 3, 2'b01);
      push_evt(c + 4, 2'b00);
      bus_if.in = 1'b1;
      tick();
      bus_if.in = 1'b0;
      tick();
    end
    repeat (8) tick();
    chk("sat_debounced", int'(bus_if.debounced), 0);
    chk_glitch("sat_glitch", 255);

    chk("exp_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
